// File: rtl/spi_master_mode.sv
`default_nettype none
// =============================================================================
// spi_master_mode : parametrised full-duplex SPI master, MSB first, all four
//                   CPOL/CPHA modes per transfer, NUM_SS active-low selects.
// Revision        : 1.0
// =============================================================================
module spi_master_mode #(
   parameter int  DATA_WIDTH = 12,
   parameter int  CLK_DIV    = 4,
   parameter int  NUM_SS     = 2,
   localparam int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic [1:0]            mode_i,
   input  logic [SS_W-1:0]       cs_sel_i,
   input  logic                  miso_i,
   output logic                  sck_o,
   output logic                  mosi_o,
   output logic [NUM_SS-1:0]     ssel_n_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] rx_data_o
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);
   localparam logic [EDGE_W-1:0] EDGE_END  = EDGE_W'(2 * DATA_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SETUP    = 2'd1,
      S_TRANSFER = 2'd2,
      S_HOLD     = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [EDGE_W-1:0]     edge_q, edge_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [1:0]            mode_q, mode_d;
   logic [NUM_SS-1:0]     ssel_n_q, ssel_n_d;
   logic                  sck_q, sck_d;
   logic                  mosi_q, mosi_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  div_wrap, lead, sample_en, shift_en;

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      edge_d    = edge_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      mode_d    = mode_q;
      ssel_n_d  = ssel_n_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      div_wrap  = (div_q == DIV_LAST);
      lead      = ~edge_q[0];
      sample_en = 1'b0;
      shift_en  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d  = S_SETUP;
               div_d    = '0;
               edge_d   = '0;
               rx_d     = '0;
               busy_d   = 1'b1;
               mode_d   = mode_i;
               sck_d    = mode_i[1];
               ssel_n_d = '1;
               for (int i = 0; i < NUM_SS; i++) begin
                  if (cs_sel_i == SS_W'(i)) ssel_n_d[i] = 1'b0;
               end
               // CPHA=0 presents the MSB before the first edge; CPHA=1 waits
               // for the first leading edge to drive it.
               if (!mode_i[0]) begin
                  mosi_d = tx_data_i[DATA_WIDTH-1];
                  tx_d   = {tx_data_i[DATA_WIDTH-2:0], 1'b0};
               end else begin
                  tx_d   = tx_data_i;
               end
            end
         end
         S_SETUP, S_TRANSFER: begin
            div_d = div_q + DIV_W'(1);
            if (div_wrap) begin
               div_d = '0;
               if (edge_q == EDGE_END) begin
                  state_d = S_HOLD;
               end else begin
                  state_d   = S_TRANSFER;
                  sck_d     = ~sck_q;
                  edge_d    = edge_q + EDGE_W'(1);
                  sample_en = mode_q[0] ? ~lead : lead;
                  shift_en  = lead ? mode_q[0] : (~mode_q[0] & (edge_q != EDGE_LAST));
               end
            end
         end
         S_HOLD: begin
            div_d = div_q + DIV_W'(1);
            if (div_wrap) begin
               div_d     = '0;
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               ssel_n_d  = '1;
               rx_data_d = rx_q;
            end
         end
         default: ;
      endcase

      if (sample_en) rx_d = {rx_q[DATA_WIDTH-2:0], miso_i};
      if (shift_en) begin
         mosi_d = tx_q[DATA_WIDTH-1];
         tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         edge_q    <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         mode_q    <= '0;
         ssel_n_q  <= '1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         edge_q    <= edge_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
         mode_q    <= mode_d;
         ssel_n_q  <= ssel_n_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign sck_o     = sck_q;
   assign mosi_o    = mosi_q;
   assign ssel_n_o  = ssel_n_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign rx_data_o = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mode.sv
`default_nettype none
// =============================================================================
// tb_spi_master_mode : randomized scoreboard bench with a behavioural SPI slave.
// Revision           : 1.0
// =============================================================================
module tb_spi_master_mode;

   localparam int DW  = 12;
   localparam int DIV = 4;
   localparam int NSS = 3;
   localparam int SSW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b1;

   logic           start;
   logic [DW-1:0]  tx_data;
   logic [1:0]     mode;
   logic [SSW-1:0] cs_sel;
   logic           miso = 1'b1;
   logic           sck, mosi, busy, done;
   logic [NSS-1:0] ssel_n;
   logic [DW-1:0]  rx_data;

   spi_master_mode #(.DATA_WIDTH(DW), .CLK_DIV(DIV), .NUM_SS(NSS)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .tx_data_i(tx_data),
      .mode_i(mode), .cs_sel_i(cs_sel), .miso_i(miso), .sck_o(sck),
      .mosi_o(mosi), .ssel_n_o(ssel_n), .busy_o(busy), .done_o(done),
      .rx_data_o(rx_data)
   );

   // Parameter-sweep instances in mosi->miso loopback
   logic s8_start = 1'b0, s8_sck, s8_mosi, s8_busy, s8_done;
   logic [7:0] s8_tx = '0, s8_rx;
   logic [1:0] s8_mode = '0;
   logic [0:0] s8_ssel;
   spi_master_mode #(.DATA_WIDTH(8), .CLK_DIV(1), .NUM_SS(1)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(s8_start), .tx_data_i(s8_tx),
      .mode_i(s8_mode), .cs_sel_i(1'b0), .miso_i(s8_mosi), .sck_o(s8_sck),
      .mosi_o(s8_mosi), .ssel_n_o(s8_ssel), .busy_o(s8_busy), .done_o(s8_done),
      .rx_data_o(s8_rx)
   );

   logic s32_start = 1'b0, s32_sck, s32_mosi, s32_busy, s32_done;
   logic [31:0] s32_tx = '0, s32_rx;
   logic [1:0]  s32_mode = '0;
   logic [0:0]  s32_ssel;
   spi_master_mode #(.DATA_WIDTH(32), .CLK_DIV(7), .NUM_SS(1)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(s32_start), .tx_data_i(s32_tx),
      .mode_i(s32_mode), .cs_sel_i(1'b0), .miso_i(s32_mosi), .sck_o(s32_sck),
      .mosi_o(s32_mosi), .ssel_n_o(s32_ssel), .busy_o(s32_busy), .done_o(s32_done),
      .rx_data_o(s32_rx)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   // ---------------- behavioural slave (any asserted select) ----------------
   logic [DW-1:0] slv_tx = '0, slv_bits = '0, slv_rx = '0;
   logic [1:0]    slv_mode = '0;
   logic          slv_lead_seen = 1'b0;
   logic          sel_any;
   assign sel_any = ~&ssel_n;

   initial forever begin
      @(sel_any);
      slv_lead_seen = 1'b0;
      if (sel_any === 1'b1) begin
         slv_bits = slv_tx;
         slv_rx   = '0;
         if (!slv_mode[0]) miso = slv_tx[DW-1];
      end else begin
         miso = 1'b1;
      end
   end

   initial forever begin
      @(sck);
      if (sel_any === 1'b1) begin
         if (sck !== slv_mode[1]) begin
            slv_lead_seen = 1'b1;
            if (!slv_mode[0]) slv_rx = {slv_rx[DW-2:0], mosi};
            else begin
               miso     = slv_bits[DW-1];
               slv_bits = {slv_bits[DW-2:0], 1'b0};
            end
         end else if (slv_lead_seen) begin
            if (!slv_mode[0]) begin
               slv_bits = {slv_bits[DW-2:0], 1'b0};
               miso     = slv_bits[DW-1];
            end else begin
               slv_rx = {slv_rx[DW-2:0], mosi};
            end
         end
      end
   end

   // ---------------- scoreboard + monitor ----------------
   typedef struct {
      logic [DW-1:0]  rx;
      logic [NSS-1:0] mask;
      logic [DW-1:0]  srx;
      logic           cpol;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   int             mon_lat = 0, mon_edges = 0;
   logic [NSS-1:0] mon_mask = '0;
   logic           prev_sck = 1'b0, prev_busy = 1'b0;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         mon_lat = 0; mon_edges = 0; mon_mask = '0;
         prev_busy = 1'b0; prev_sck = sck;
      end else begin
         if (busy) begin
            mon_lat++;
            mon_mask |= ~ssel_n;
            if (prev_busy && sck !== prev_sck) mon_edges++;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_done: got done=1, expected no done");
            end else begin
               mon_e = exp_q.pop_front();
               check("rx_data",   64'(rx_data),   64'(mon_e.rx));
               check("ssel_mask", 64'(mon_mask),  64'(mon_e.mask));
               check("latency",   64'(mon_lat),   64'(DIV * (2 * DW + 2)));
               check("sck_edges", 64'(mon_edges), 64'(2 * DW));
               check("sck_idle",  64'(sck),       64'(mon_e.cpol));
               check("ssel_done", 64'(ssel_n),    64'({NSS{1'b1}}));
               if (mon_e.mask != '0) check("slave_rx", 64'(slv_rx), 64'(mon_e.srx));
            end
            mon_lat = 0; mon_edges = 0; mon_mask = '0;
         end
         prev_sck  = sck;
         prev_busy = busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      if (busy) fail_now("idle_timeout");
   endtask

   task automatic wait_done();
      int n = 0;
      while (n < 2000) begin
         @(posedge clk); #1; n++;
         if (done) break;
      end
      if (!done) fail_now("done_timeout");
   endtask

   task automatic push_exp(input logic [DW-1:0] tx, input logic [1:0] md,
                           input logic [SSW-1:0] cs, input logic [DW-1:0] stx);
      exp_t e;
      e.rx   = (cs < NSS) ? stx : {DW{1'b1}};
      e.mask = (cs < NSS) ? (NSS'(1) << cs) : '0;
      e.srx  = tx;
      e.cpol = md[1];
      exp_q.push_back(e);
   endtask

   task automatic launch(input logic [DW-1:0] tx, input logic [1:0] md,
                         input logic [SSW-1:0] cs, input logic [DW-1:0] stx,
                         input bit exp_done);
      wait_idle();
      slv_tx   = stx;
      slv_mode = md;
      if (exp_done) push_exp(tx, md, cs, stx);
      tx_data = tx; mode = md; cs_sel = cs; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic xfer(input logic [DW-1:0] tx, input logic [1:0] md,
                       input logic [SSW-1:0] cs, input logic [DW-1:0] stx);
      launch(tx, md, cs, stx, 1'b1);
      wait_done();
   endtask

   task automatic run8(input logic [7:0] tx, input logic [1:0] md);
      int cnt = 0;
      s8_tx = tx; s8_mode = md; s8_start = 1'b1;
      @(posedge clk); #1; s8_start = 1'b0;
      while (cnt < 200) begin
         @(posedge clk); cnt++; #1;
         if (s8_done) break;
      end
      check("sw8_latency", 64'(cnt), 64'(1 * (2 * 8 + 2)));
      check("sw8_rx", 64'(s8_rx), 64'(tx));
      check("sw8_sck_idle", 64'(s8_sck), 64'(md[1]));
      check("sw8_ssel_idle", 64'({s8_ssel, s8_busy}), 64'(2'b10));
   endtask

   task automatic run32(input logic [31:0] tx, input logic [1:0] md);
      int cnt = 0;
      s32_tx = tx; s32_mode = md; s32_start = 1'b1;
      @(posedge clk); #1; s32_start = 1'b0;
      while (cnt < 1000) begin
         @(posedge clk); cnt++; #1;
         if (s32_done) break;
      end
      check("sw32_latency", 64'(cnt), 64'(7 * (2 * 32 + 2)));
      check("sw32_rx", 64'(s32_rx), 64'(tx));
      check("sw32_ssel_idle", 64'({s32_ssel, s32_busy, s32_sck}), 64'({2'b10, md[1]}));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] a, b;
   logic [1:0]    m;

   initial begin
      start = 1'b0; tx_data = '0; mode = '0; cs_sel = '0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_sck",    64'(sck),     64'(0));
      check("rst_mosi",   64'(mosi),    64'(0));
      check("rst_ssel",   64'(ssel_n),  64'({NSS{1'b1}}));
      check("rst_busy",   64'(busy),    64'(0));
      check("rst_done",   64'(done),    64'(0));
      check("rst_rxdata", 64'(rx_data), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // mode-0 loopback with fixed words, then the other three modes
      xfer(12'hA5C, 2'd0, 2'd0, 12'h82A);
      for (int md = 1; md < 4; md++)
         xfer(DW'($urandom), 2'(md), 2'd0, DW'($urandom));
      check("mode3_sck_idle", 64'(sck), 64'(1));

      // select routing, including an index with no slave behind it
      xfer(DW'($urandom), 2'd0, 2'd1, DW'($urandom));
      xfer(DW'($urandom), 2'd1, 2'd3, DW'($urandom));

      for (int i = 0; i < 10; i++)
         xfer(DW'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), DW'($urandom));

      // start pulsed mid-transfer must be ignored
      a = DW'($urandom); m = 2'($urandom_range(0, 3));
      launch(a, m, 2'd2, DW'($urandom), 1'b1);
      repeat (30) @(posedge clk); #1;
      tx_data = ~a; mode = ~m; cs_sel = 2'd0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done();

      // start held through done: back-to-back with a one-cycle select gap
      wait_idle();
      a = DW'($urandom); b = DW'($urandom); m = 2'($urandom_range(0, 3));
      slv_tx = b; slv_mode = m;
      push_exp(a, m, 2'd0, b);
      tx_data = a; mode = m; cs_sel = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      a = DW'($urandom); b = DW'($urandom);
      push_exp(a, m, 2'd0, b);
      tx_data = a; slv_tx = b;
      wait_done();
      check("b2b_gap_ssel", 64'(ssel_n), 64'({NSS{1'b1}}));
      @(posedge clk); #1; start = 1'b0;
      check("b2b_reselect", 64'({busy, ssel_n}), 64'({1'b1, 3'b110}));
      wait_done();

      // asynchronous reset around bit 5 of a transfer
      launch(DW'($urandom), 2'd0, 2'd0, DW'($urandom), 1'b0);
      repeat (DIV * 11) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_sck",    64'(sck),     64'(0));
      check("arst_mosi",   64'(mosi),    64'(0));
      check("arst_ssel",   64'(ssel_n),  64'({NSS{1'b1}}));
      check("arst_busy",   64'(busy),    64'(0));
      check("arst_done",   64'(done),    64'(0));
      check("arst_rxdata", 64'(rx_data), 64'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(DW'($urandom), 2'd2, 2'd1, DW'($urandom));

      // parameter sweep, all four modes each
      for (int md = 0; md < 4; md++) begin
         run8(8'($urandom), 2'(md));
         run32(32'($urandom), 2'(md));
      end

      repeat (5) @(posedge clk); #1;
      check("sb_drained", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
